// File: rtl/lim_dec_timer.sv
// MM:SS countdown timer built from four limited BCD-style decrementors.
// A small control FSM owns load, run/pause and expiry.

module lim_dec_digit #(
    parameter int unsigned L = 10
) (
    input  logic [3:0] d,
    input  logic       b_in,
    output logic [3:0] q,
    output logic       b_out
);

    localparam logic [3:0] LM1 = 4'(L - 1);

    always_comb begin
        q     = d;
        b_out = 1'b0;
        if (b_in) begin
            if (d != 4'd0) begin
                q = d - 4'd1;
            end else begin
                q     = LM1;
                b_out = 1'b1;
            end
        end
    end

endmodule

module lim_dec_timer #(
    parameter int unsigned L0 = 10,
    parameter int unsigned L1 = 6,
    parameter int unsigned L2 = 10,
    parameter int unsigned L3 = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start_stop,
    output logic [15:0] digits,
    output logic        running,
    output logic        expired,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dig_q, dig_d;
    logic [15:0] dec;
    logic [15:0] clamped;
    logic [3:0]  b;

    function automatic logic [3:0] clamp(
        input logic [3:0]  v,
        input int unsigned lim
    );
        logic [4:0] l5;
        l5 = 5'(lim);
        if ({1'b0, v} >= l5) begin
            return 4'(l5 - 5'd1);
        end
        return v;
    endfunction

    assign clamped = {clamp(load_val[15:12], L3),
                      clamp(load_val[11:8],  L2),
                      clamp(load_val[7:4],   L1),
                      clamp(load_val[3:0],   L0)};

    // Borrow ripples d0 -> d3 so the whole value steps in one edge.
    lim_dec_digit #(.L(L0)) u_d0 (
        .d(dig_q[3:0]),   .b_in(1'b1),
        .q(dec[3:0]),     .b_out(b[0])
    );
    lim_dec_digit #(.L(L1)) u_d1 (
        .d(dig_q[7:4]),   .b_in(b[0]),
        .q(dec[7:4]),     .b_out(b[1])
    );
    lim_dec_digit #(.L(L2)) u_d2 (
        .d(dig_q[11:8]),  .b_in(b[1]),
        .q(dec[11:8]),    .b_out(b[2])
    );
    lim_dec_digit #(.L(L3)) u_d3 (
        .d(dig_q[15:12]), .b_in(b[2]),
        .q(dec[15:12]),   .b_out(b[3])
    );

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        if (load) begin
            dig_d   = clamped;
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_stop) begin
                        state_d = (dig_q != 16'd0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (start_stop) begin
                        state_d = S_PAUSE;
                    end else if (tick) begin
                        // A borrow out of d3 would mean a wrap; hold at zero.
                        if (b[3]) begin
                            dig_d   = 16'd0;
                            state_d = S_DONE;
                        end else begin
                            dig_d = dec;
                            if (dec == 16'd0) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (start_stop) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            dig_q   <= 16'd0;
            running <= 1'b0;
            expired <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            running <= (state_d == S_RUN);
            expired <= (state_d == S_DONE);
            done    <= (state_d == S_DONE) && (state_q != S_DONE);
        end
    end

    assign digits = dig_q;

endmodule
